game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Top-level game sequencer for the snake design. Owns the game_state bus that the score
//  counter, snake engine and display consume: start/pause/restart/game-over FSM, a
//  movement-step pulse whose period shortens as food is eaten, and a session high score.
// PARAMETERS
//  STEP_BASE        25_000_000  clk cycles per move at level 0
//  STEP_DEC          1_000_000  period reduction per level
//  STEP_MIN          5_000_000  period floor
//  FOODS_PER_LEVEL           4  foods eaten per level increment (>=1)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  btn_start   in   1   debounced, clk-synchronous level; rising edge = start/restart
//  btn_pause   in   1   debounced, clk-synchronous level; rising edge = pause toggle
//  collision   in   1   1-cycle pulse from snake engine: wall/self hit
//  get_food    in   1   1-cycle pulse from snake engine: food eaten
//  game_state  out  2   00 PLAY, 01 PAUSE, 10 RESET, 11 OVER (registered)
//  step        out  1   1-cycle move pulse, only in PLAY
//  level       out  4   current speed level, 0..15
//  high_score  out  16  best completed-run score this power-up
// BEHAVIOUR
//  - Reset: game_state=RESET, step=0, level=0, high_score=0, run_score=0, divider=0,
//    button edge-detect registers=0 (a button held through reset gives no edge).
//  - Edges: start_e/pause_e = level & ~level_d; 1-cycle latency from input to state change.
//  - FSM (next state visible the cycle after the event):
//    RESET: start_e -> PLAY; run_score, food count, level, divider held at 0.
//    PLAY : collision -> OVER; else pause_e -> PAUSE; start_e ignored.
//    PAUSE: pause_e -> PLAY; start_e -> RESET (start wins if both); divider frozen.
//    OVER : start_e -> RESET; pause_e ignored.
//  - get_food counted only when game_state==PLAY in that cycle: run_score+1 (16-bit wrap,
//    identical to score counter), food count+1; level=min(15, foods/FOODS_PER_LEVEL).
//  - collision and get_food in same PLAY cycle: food counted, then OVER.
//  - Step timer: counts in PLAY only; at count==period-1 asserts step for 1 cycle, restarts
//    at 0 and loads period=max(STEP_MIN, STEP_BASE-level*STEP_DEC) for next interval (period
//    never changes mid-interval). First step arrives period cycles after entering PLAY.
//    PAUSE freezes count; PAUSE->PLAY resumes from frozen count. RESET/OVER clear it.
//  - Arithmetic: period math in 32 bits, unsigned; floor applied before compare, no underflow.
//  - high_score: in the first OVER cycle, high_score <= max(high_score, run_score);
//    unsigned compare. Not cleared by RESET state; only by rst_n.
//  - rst_n asserted mid-run: immediate return to reset values, no step glitch.
// CONFIGURATION
//  - HIGH_SCORE_EN defined: high_score register and compare built as above.
//  - HIGH_SCORE_EN undefined: no register; high_score tied to 16'h0000; all else identical.
// STRUCTURE
//  - game_pkg: state encodings ST_PLAY=2'b00, ST_PAUSE=2'b01, ST_RESET=2'b10, ST_OVER=2'b11,
//    shared with score counter and snake engine; LEVEL_MAX=15.
//  - One sub-module: step_timer (programmable divider: en, clr, period in, tick out,
//    period latched at terminal count). FSM, edge detect, level and score logic in game_ctrl.
// TESTING (run with STEP_BASE=20, STEP_DEC=4, STEP_MIN=8, FOODS_PER_LEVEL=2)
//  1 rst_n low then high, start edge -> state 10 then 00 one cycle later; step at 20 cycles, every 20.
//  2 4 get_food pulses in PLAY -> level 2, next interval 12 cycles; 10 foods -> period floor 8.
//  3 pause edge at divider count 7 -> state 01, no step for 100 cycles; pause edge -> step 13 cycles after resume.
//  4 collision+get_food same cycle with run_score 5 -> state 11, high_score 6; next run ends at 3 -> high_score stays 6.
//  5 get_food in PAUSE/OVER/RESET -> run_score, level unchanged; start in PLAY ignored; start+pause in PAUSE -> RESET.
//  6 rst_n pulse mid-PLAY -> all outputs at reset values asynchronously; without HIGH_SCORE_EN high_score always 0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: game_state encodings shared by the snake blocks, plus the move-period helper.
`default_nettype none
package game_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_PAUSE = 2'b01,
    ST_RESET = 2'b10,
    ST_OVER  = 2'b11
  } game_state_e;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

  // Floor is applied before the subtraction is trusted, so the result never underflows.
  function automatic logic [31:0] calc_period(input logic [3:0]  lvl,
                                              input logic [31:0] base,
                                              input logic [31:0] dec,
                                              input logic [31:0] floor_v);
    logic [31:0] red;
    red = 32'(lvl) * dec;
    if ((red >= base) || ((base - red) < floor_v)) return floor_v;
    return base - red;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_ctrl_step_timer.sv
// step_timer: programmable divider; the period is latched on clear and at terminal count only.
`default_nettype none
module step_timer #(
  parameter int unsigned RST_PERIOD = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic [31:0] i_period,
  output logic        o_tick
);

  logic [31:0] r_cnt;
  logic [31:0] r_period;

  assign o_tick = i_en && (r_cnt == (r_period - 32'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_period <= 32'(RST_PERIOD);
    end else if (i_clr || o_tick) begin
      r_cnt    <= '0;
      r_period <= i_period;
    end else if (i_en) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
// game_ctrl: snake game sequencer (FSM, speed level, move-step pulse, session high score).
// Build option: define HIGH_SCORE_EN to build the high-score register; otherwise it reads 0.
`default_nettype none
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned STEP_BASE       = 25_000_000,
  parameter int unsigned STEP_DEC        = 1_000_000,
  parameter int unsigned STEP_MIN        = 5_000_000,
  parameter int unsigned FOODS_PER_LEVEL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        collision,
  input  logic        get_food,
  output logic [1:0]  game_state,
  output logic        step,
  output logic [3:0]  level,
  output logic [15:0] high_score
);

  localparam int FW = $clog2(FOODS_PER_LEVEL + 1);

  game_state_e r_state, w_next;
  logic        r_start_d, r_pause_d, r_armed;
  logic        w_start_e, w_pause_e, w_play, w_food, w_tick;
  logic [FW-1:0] r_food_cnt;
  logic [3:0]  r_level;
  logic        r_step;
  logic [31:0] w_period;

  // r_armed masks the first cycle after reset so a button held through reset gives no edge.
  assign w_start_e = r_armed && btn_start && !r_start_d;
  assign w_pause_e = r_armed && btn_pause && !r_pause_d;
  assign w_play    = (r_state == ST_PLAY);
  assign w_food    = w_play && get_food;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_d <= 1'b0;
      r_pause_d <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_start_d <= btn_start;
      r_pause_d <= btn_pause;
      r_armed   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET: if (w_start_e) w_next = ST_PLAY;
      ST_PLAY: begin
        if (collision)      w_next = ST_OVER;
        else if (w_pause_e) w_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_start_e)      w_next = ST_RESET;
        else if (w_pause_e) w_next = ST_PLAY;
      end
      ST_OVER: if (w_start_e) w_next = ST_RESET;
      default: w_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_food_cnt <= '0;
      r_level    <= '0;
    end else if (r_state == ST_RESET) begin
      r_food_cnt <= '0;
      r_level    <= '0;
    end else if (w_food && (r_level != LEVEL_MAX)) begin
      if (r_food_cnt == FW'(FOODS_PER_LEVEL - 1)) begin
        r_food_cnt <= '0;
        r_level    <= r_level + 4'd1;
      end else begin
        r_food_cnt <= r_food_cnt + FW'(1);
      end
    end
  end

  assign w_period = calc_period(r_level, 32'(STEP_BASE), 32'(STEP_DEC), 32'(STEP_MIN));

  step_timer #(
    .RST_PERIOD (STEP_BASE)
  ) u_step_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_play),
    .i_clr    ((r_state == ST_RESET) || (r_state == ST_OVER)),
    .i_period (w_period),
    .o_tick   (w_tick)
  );

  // A tick coinciding with a transition out of PLAY is dropped so step only shows in PLAY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_step <= 1'b0;
    else        r_step <= w_tick && (w_next == ST_PLAY);
  end

`ifdef HIGH_SCORE_EN
  logic [15:0] r_run_score;
  logic [15:0] r_high_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_score  <= '0;
      r_high_score <= '0;
    end else begin
      if (r_state == ST_RESET) r_run_score <= '0;
      else if (w_food)         r_run_score <= r_run_score + 16'd1;
      if ((r_state == ST_OVER) && (r_run_score > r_high_score))
        r_high_score <= r_run_score;
    end
  end

  assign high_score = r_high_score;
`else
  assign high_score = 16'h0000;
`endif

  assign game_state = r_state;
  assign step       = r_step;
  assign level      = r_level;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: randomized stimulus, behavioural model feeds a scoreboard queue checked per cycle.
`default_nettype none
module tb_game_ctrl;

  localparam int SB  = 20;
  localparam int SD  = 4;
  localparam int SM  = 8;
  localparam int FPL = 2;

  localparam int P_PLAY  = 0;
  localparam int P_PAUSE = 1;
  localparam int P_RESET = 2;
  localparam int P_OVER  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_pause = 1'b0;
  logic        collision = 1'b0;
  logic        get_food = 1'b0;
  logic [1:0]  game_state;
  logic        step;
  logic [3:0]  level;
  logic [15:0] high_score;

  game_ctrl #(
    .STEP_BASE       (SB),
    .STEP_DEC        (SD),
    .STEP_MIN        (SM),
    .FOODS_PER_LEVEL (FPL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .collision  (collision),
    .get_food   (get_food),
    .game_state (game_state),
    .step       (step),
    .level      (level),
    .high_score (high_score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        stp;
    logic [3:0]  lv;
    logic [15:0] hs;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: game rules expressed on plain integers.
  int m_st, m_cnt, m_per, m_foods, m_run, m_hs;
  bit m_step, m_armed, m_ps, m_pp;

  function automatic int period_of(int lv);
    int p;
    p = SB - lv * SD;
    return (p < SM) ? SM : p;
  endfunction

  function automatic int level_of(int f);
    return (f / FPL > 15) ? 15 : f / FPL;
  endfunction

  task automatic model_reset();
    m_st = P_RESET; m_cnt = 0; m_per = SB; m_foods = 0; m_run = 0; m_hs = 0;
    m_step = 0; m_armed = 0; m_ps = 0; m_pp = 0;
  endtask

  task automatic model_clock(bit s, bit p, bit c, bit f);
    bit se, pe, eat;
    int nst, lv;
    se = m_armed && s && !m_ps;
    pe = m_armed && p && !m_pp;
    m_ps = s; m_pp = p; m_armed = 1;
    lv  = level_of(m_foods);
    eat = f && (m_st == P_PLAY);
    nst = m_st;
    case (m_st)
      P_RESET: if (se) nst = P_PLAY;
      P_PLAY:  if (c) nst = P_OVER; else if (pe) nst = P_PAUSE;
      P_PAUSE: if (se) nst = P_RESET; else if (pe) nst = P_PLAY;
      default: if (se) nst = P_RESET;
    endcase
    m_step = 0;
    if (m_st == P_PLAY) begin
      if (m_cnt == m_per - 1) begin
        m_cnt = 0; m_per = period_of(lv); m_step = (nst == P_PLAY);
      end else begin
        m_cnt++;
      end
    end else if (m_st != P_PAUSE) begin
      m_cnt = 0; m_per = period_of(lv);
    end
    if (m_st == P_OVER && m_run > m_hs) m_hs = m_run;
    if (m_st == P_RESET) begin
      m_run = 0; m_foods = 0;
    end else if (eat) begin
      m_run = (m_run + 1) % 65536; m_foods++;
    end
    m_st = nst;
  endtask

  task automatic drive(bit rn, bit s, bit p, bit c, bit f);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = rn; btn_start = s; btn_pause = p; collision = c; get_food = f;
    if (!rn) model_reset();
    else     model_clock(s, p, c, f);
    e.st  = 2'(m_st);
    e.stp = m_step;
    e.lv  = 4'(level_of(m_foods));
`ifdef HIGH_SCORE_EN
    e.hs  = 16'(m_hs);
`else
    e.hs  = 16'h0000;
`endif
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        n_tests++;
        if ({game_state, step, level, high_score} !== mon_e) begin
          n_fail++;
          if (n_fail <= 10)
            $display("FAIL outputs @%0t: got st=%b step=%b lvl=%0d hs=%0d, need st=%b step=%b lvl=%0d hs=%0d",
                     $time, game_state, step, level, high_score,
                     mon_e.st, mon_e.stp, mon_e.lv, mon_e.hs);
        end
      end
    end
  end

  initial begin
    bit s, p, c, f, rn;
    model_reset();
    // start held through reset must not count as an edge
    repeat (3) drive(0, 1, 0, 0, 0);
    repeat (4) drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    repeat (45) drive(1, 1, 0, 0, 0);
    // 10 foods then a few intervals at the floor period
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0);
    end
    repeat (40) drive(1, 0, 0, 0, 0);
    // pause, long freeze, resume
    drive(1, 0, 1, 0, 0);
    repeat (100) drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    repeat (30) drive(1, 0, 0, 0, 0);
    // collision with food in the same cycle, then food while OVER
    drive(1, 0, 0, 1, 1);
    repeat (3) drive(1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 1);
    s = 0; p = 0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 39) == 0) s = !s;
      if ($urandom_range(0, 59) == 0) p = !p;
      c  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 7) == 0);
      if (c && $urandom_range(0, 1) == 1) f = 1;
      rn = ($urandom_range(0, 1999) != 0);
      drive(rn, s, p, c, f);
    end
    repeat (3) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
